// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
//   APB bus bundle between the bridge (initiator) and the peripheral slaves.
//   Signal names follow the AMBA APB naming used throughout the SoC.
//
//   Parameters
//     NUM_SLV  number of APB slaves (width of PSEL / PREADY)
//
//   Signals
//     PADDR    initiator -> slaves  32            byte address
//     PWRITE   initiator -> slaves  1             1 = write
//     PWDATA   initiator -> slaves  32            write data
//     PENABLE  initiator -> slaves  1             ACCESS phase marker
//     PSEL     initiator -> slaves  NUM_SLV       one-hot slave select
//     PRDATA   slaves -> initiator  32*NUM_SLV    slave i read data at [32*i +: 32]
//     PREADY   slaves -> initiator  NUM_SLV       per-slave ready
//
//   Modports: master (the bridge), slave (peripheral side).
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
  parameter int NUM_SLV = 4
);
  logic [31:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic                  PENABLE;
  logic [NUM_SLV-1:0]    PSEL;
  logic [32*NUM_SLV-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;

  modport master (
    output PADDR, PWRITE, PWDATA, PENABLE, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PWDATA, PENABLE, PSEL,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB initiator between the CPU data bus and the APB peripherals.
//   A single-cycle CPU request starts one APB SETUP -> ACCESS transfer; the
//   address is decoded to one PSEL line, the selected PRDATA/PREADY are muxed
//   back and a one-cycle ready pulse (with err) completes the request.
//   Only one transfer is outstanding; requests outside IDLE are dropped.
//
//   Parameters
//     NUM_SLV      number of APB slaves, 1..16
//     BASE_ADDR    base of the peripheral window (aligned to the whole window)
//     SPAN_LOG2    log2 of bytes per slave window
//     TIMEOUT_CYC  ACCESS cycles before abort (only with APB_TIMEOUT_EN)
//
//   Ports
//     PCLK      in   clock
//     PRESET    in   asynchronous, active-high reset
//     transfer  in   CPU request strobe, sampled only in IDLE
//     write     in   1 = write, 0 = read
//     addr      in   CPU byte address
//     wdata     in   CPU write data
//     rdata     out  read data, valid while ready=1
//     ready     out  one-cycle completion pulse
//     err       out  error flag, valid while ready=1
//     apb       --   APB bus (master modport of apb_master_bridge_if)
//
//   Build option
//     APB_TIMEOUT_EN  when defined, an ACCESS phase that has not seen PREADY
//                     by its TIMEOUT_CYC-th cycle completes with err=1 and
//                     rdata=32'hDEAD_BEEF. Undefined: ACCESS waits forever.
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SPAN_LOG2   = 12,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 transfer,
  input  logic                 write,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 ready,
  output logic                 err,
  apb_master_bridge_if.master  apb
);

  localparam int              IDX_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int              TOP       = SPAN_LOG2 + IDX_W;
  localparam logic [IDX_W:0]  NUM_SLV_W = NUM_SLV[IDX_W:0];

  // Parameter sanity checks, evaluated at elaboration only.
  if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
    $error("apb_master_bridge: NUM_SLV must be 1..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYC must be 1..256");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [31:0]       paddr_q, pwdata_q;
  logic              pwrite_q;
  logic [IDX_W-1:0]  sel_q;

  // ---------------------------------------------------------------------------
  // Address decode of the incoming CPU request
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] idx;
  logic             mapped;
  logic             accept;

  assign idx    = addr[SPAN_LOG2 +: IDX_W];
  assign mapped = (addr[31:TOP] == BASE_ADDR[31:TOP]) && ({1'b0, idx} < NUM_SLV_W);
  assign accept = (state == IDLE) && transfer && mapped;

  // ---------------------------------------------------------------------------
  // Selected-slave return path and one-hot select
  // ---------------------------------------------------------------------------
  logic               sel_pready;
  logic [31:0]        sel_prdata;
  logic [NUM_SLV-1:0] sel_onehot;

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_pready = 1'b0;
    sel_prdata = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_pready    = apb.PREADY[i];
        sel_prdata    = apb.PRDATA[32*i +: 32];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional ACCESS watchdog
  // ---------------------------------------------------------------------------
  logic timeout;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;

  // Cleared while in SETUP so it reads 0 in the first ACCESS cycle; counts
  // only the cycles the selected slave is still stalling.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !sel_pready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A PREADY in the last allowed cycle still wins over the abort.
  assign timeout = (state == ACCESS) && !sel_pready && (wait_cnt == WAIT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (transfer) begin
          state_next = mapped ? SETUP : ERROR;
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (sel_pready || timeout) begin
          state_next = IDLE;
        end
      end
      ERROR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (combinational from state and the selected slave)
  // ---------------------------------------------------------------------------
  logic [NUM_SLV-1:0] psel;
  logic               penable;

  always_comb begin
    psel    = '0;
    penable = 1'b0;
    ready   = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    unique case (state)
      SETUP: begin
        psel = sel_onehot;
      end
      ACCESS: begin
        psel    = sel_onehot;
        penable = 1'b1;
        if (sel_pready) begin
          ready = 1'b1;
          rdata = pwrite_q ? 32'h0 : sel_prdata;
        end else if (timeout) begin
          ready = 1'b1;
          err   = 1'b1;
          rdata = 32'hDEAD_BEEF;
        end
      end
      ERROR: begin
        ready = 1'b1;
        err   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request registers: loaded only when a mapped request is accepted, so an
  // unmapped request leaves the previous APB address/data on the bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
    end else if (accept) begin
      paddr_q  <= addr;
      pwdata_q <= wdata;
      pwrite_q <= write;
      sel_q    <= idx;
    end
  end

  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge (4 slaves, 4 KB windows at
//   0x1000_0000). A slave model answers the addressed slave after a chosen
//   number of stalled ACCESS cycles while every other slave drives PREADY=1
//   and junk PRDATA. Expected results come from a transaction-level model of
//   the memory map and latency rules.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        PCLK;
  logic        PRESET;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  apb_master_bridge_if #(.NUM_SLV(NS)) apb_bus ();

  apb_master_bridge #(
    .NUM_SLV     (NS),
    .BASE_ADDR   (BASE),
    .SPAN_LOG2   (12),
    .TIMEOUT_CYC (16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .apb      (apb_bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: memory map, latency and the APB register contents
  // ---------------------------------------------------------------------------
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic        m_pwrite;

  function automatic bit model_mapped(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(NS) * 32'd4096);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4096);
  endfunction

  task automatic model_expect(input bit wr, input logic [31:0] a, input logic [31:0] rd,
                              input int stall, output int lat, output logic e,
                              output logic [31:0] r, output logic [3:0] ps);
    if (!model_mapped(a)) begin
      lat = 1; e = 1'b1; r = 32'h0; ps = 4'b0000;
    end else begin
      ps = 4'(1 << model_idx(a));
`ifdef APB_TIMEOUT_EN
      if (stall >= 16) begin
        lat = 2 + 15; e = 1'b1; r = 32'hDEAD_BEEF;
      end else begin
        lat = 2 + stall; e = 1'b0; r = wr ? 32'h0 : rd;
      end
`else
      lat = 2 + stall; e = 1'b0; r = wr ? 32'h0 : rd;
`endif
    end
  endtask

  task automatic model_reset();
    m_paddr  = '0;
    m_pwdata = '0;
    m_pwrite = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Drive one CPU request and act as the slave side until ready (or budget).
  // hold=1 keeps re-requesting a different address during SETUP/ACCESS.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int stall, input bit hold,
                         input int budget,
                         output int lat, output logic busy0, output logic [31:0] g_rdata,
                         output logic g_err, output logic [3:0] g_psel, output logic g_pen,
                         output logic [31:0] g_paddr, output logic [31:0] g_pwdata,
                         output logic g_pwrite, output logic bad_sel);
    int         tgt;
    int         acc;
    logic [3:0] mask;
    tgt  = model_mapped(a) ? model_idx(a) : -1;
    mask = (tgt >= 0) ? 4'(1 << tgt) : 4'b0000;
    lat = -1; acc = 0; busy0 = 1'b0; g_rdata = '0; g_err = 1'b0; g_psel = '0;
    g_pen = 1'b0; g_paddr = '0; g_pwdata = '0; g_pwrite = 1'b0; bad_sel = 1'b0;
    for (int k = 0; k <= budget; k++) begin
      @(negedge PCLK);
      if (k == 0) begin
        for (int s = 0; s < NS; s++)
          apb_bus.PRDATA[32*s +: 32] = (s == tgt) ? rd : (32'hBAD0_0000 | 32'(s));
        apb_bus.PREADY = ~mask;
        transfer = 1'b1; write = wr; addr = a; wdata = wd;
      end else begin
        transfer = hold;
        write    = ~wr;
        addr     = hold ? (a ^ 32'h0000_1000) : $urandom;
        wdata    = $urandom;
      end
      #1;
      if (k == 0) busy0 = ready | apb_bus.PENABLE | (|apb_bus.PSEL);
      if (tgt >= 0) begin
        if (apb_bus.PSEL[tgt] && apb_bus.PENABLE) begin
          apb_bus.PREADY[tgt] = (acc == stall);
          acc++;
        end else begin
          apb_bus.PREADY[tgt] = 1'b0;
        end
      end
      #1;
      if ($countones(apb_bus.PSEL) > 1 || (apb_bus.PENABLE && $countones(apb_bus.PSEL) != 1))
        bad_sel = 1'b1;
      if (k == 1) begin
        g_psel = apb_bus.PSEL;
        g_pen  = apb_bus.PENABLE;
      end
      if (ready) begin
        lat      = k;
        g_rdata  = rdata;
        g_err    = err;
        g_paddr  = apb_bus.PADDR;
        g_pwdata = apb_bus.PWDATA;
        g_pwrite = apb_bus.PWRITE;
        break;
      end
    end
  endtask

  task automatic check_txn(input string name, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int stall,
                           input bit hold, input int budget, input int exp_lat,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input logic [3:0] exp_psel);
    int          lat;
    logic        busy0, g_err, g_pen, g_pwrite, bad_sel;
    logic [31:0] g_rdata, g_paddr, g_pwdata;
    logic [3:0]  g_psel;
    run_txn(wr, a, wd, rd, stall, hold, budget, lat, busy0, g_rdata, g_err, g_psel,
            g_pen, g_paddr, g_pwdata, g_pwrite, bad_sel);
    if (model_mapped(a)) begin
      m_paddr = a; m_pwdata = wd; m_pwrite = wr;
    end
    check({name, ".idle_at_T"}, 32'(busy0), 32'h0);
    check({name, ".latency"},   32'(lat), 32'(exp_lat));
    check({name, ".err"},       32'(g_err), 32'(exp_err));
    check({name, ".rdata"},     g_rdata, exp_rdata);
    check({name, ".psel_T1"},   32'(g_psel), 32'(exp_psel));
    check({name, ".penable_T1"},32'(g_pen), 32'h0);
    check({name, ".paddr"},     g_paddr, m_paddr);
    check({name, ".pwdata"},    g_pwdata, m_pwdata);
    check({name, ".pwrite"},    32'(g_pwrite), 32'(m_pwrite));
    check({name, ".psel_onehot"}, 32'(bad_sel), 32'h0);
  endtask

  task automatic idle_checks(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      transfer = 1'b0;
      #2;
      check({name, ".no_extra_ready"}, 32'(ready), 32'h0);
      check({name, ".no_psel"},        32'(apb_bus.PSEL), 32'h0);
    end
  endtask

  task automatic apply_reset();
    @(negedge PCLK);
    #1 PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          stall;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_psel;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"wr_slv1",     1'b1, 32'h1000_1004, 32'h0000_00A5, 32'hDEAD_0001, 1, 1'b0, 32'h0,          4'b0010, 3};
    vecs[1] = '{"rd_stall",    1'b0, 32'h1000_2004, 32'h1111_1111, 32'h0000_005C, 3, 1'b0, 32'h0000_005C,  4'b0100, 5};
    vecs[2] = '{"unmap_hi",    1'b0, 32'h1000_4000, 32'h2222_2222, 32'h0000_0077, 0, 1'b1, 32'h0,          4'b0000, 1};
    vecs[3] = '{"unmap_far",   1'b0, 32'h2000_0000, 32'h3333_3333, 32'h0000_0088, 0, 1'b1, 32'h0,          4'b0000, 1};
    vecs[4] = '{"rd_top_0ws",  1'b0, 32'h1000_3FFC, 32'h4444_4444, 32'h1234_5678, 0, 1'b0, 32'h1234_5678,  4'b1000, 2};
    vecs[5] = '{"wr_base_0ws", 1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0BAD_0BAD, 0, 1'b0, 32'h0,          4'b0001, 2};
    vecs[6] = '{"unmap_low",   1'b1, 32'h0FFF_FFFC, 32'h5555_5555, 32'h0,         0, 1'b1, 32'h0,          4'b0000, 1};

    PRESET = 1'b1;
    transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    apb_bus.PREADY = '0;
    apb_bus.PRDATA = '0;
    model_reset();

    // Reset state
    @(negedge PCLK);
    #1;
    check("reset.paddr",   apb_bus.PADDR, 32'h0);
    check("reset.pwdata",  apb_bus.PWDATA, 32'h0);
    check("reset.pwrite",  32'(apb_bus.PWRITE), 32'h0);
    check("reset.psel",    32'(apb_bus.PSEL), 32'h0);
    check("reset.penable", 32'(apb_bus.PENABLE), 32'h0);
    check("reset.rdata",   rdata, 32'h0);
    check("reset.ready",   32'(ready), 32'h0);
    check("reset.err",     32'(err), 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Table-driven directed transfers, back to back
    for (int i = 0; i < 7; i++)
      check_txn(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].prdata,
                vecs[i].stall, 1'b0, 40, vecs[i].exp_lat, vecs[i].exp_err,
                vecs[i].exp_rdata, vecs[i].exp_psel);
    idle_checks("after_table", 1);

    // Requests during SETUP/ACCESS are dropped
    check_txn("ignored_req", 1'b0, 32'h1000_2010, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 40,
              4, 1'b0, 32'hCAFE_F00D, 4'b0100);
    idle_checks("ignored_req", 3);

    // Stalled ACCESS: watchdog abort, or indefinite wait without it
`ifdef APB_TIMEOUT_EN
    check_txn("timeout", 1'b0, 32'h1000_3010, 32'h0, 32'h0000_1234, 1000, 1'b0, 40,
              17, 1'b1, 32'hDEAD_BEEF, 4'b1000);
    idle_checks("after_timeout", 1);
`else
    begin
      int          lat;
      logic        busy0, g_err, g_pen, g_pwrite, bad_sel;
      logic [31:0] g_rdata, g_paddr, g_pwdata;
      logic [3:0]  g_psel;
      run_txn(1'b0, 32'h1000_3010, 32'h0, 32'h0000_1234, 1000, 1'b0, 102, lat, busy0,
              g_rdata, g_err, g_psel, g_pen, g_paddr, g_pwdata, g_pwrite, bad_sel);
      check("no_timeout.no_ready",  32'(lat), 32'hFFFF_FFFF);
      check("no_timeout.penable",   32'(apb_bus.PENABLE), 32'h1);
      check("no_timeout.psel",      32'(apb_bus.PSEL), 32'b1000);
      apply_reset();
    end
`endif

    // Reset while PENABLE is high
    @(negedge PCLK);
    apb_bus.PREADY = 4'b0111;
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_3000; wdata = 32'h0;
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    #1;
    check("mid_reset.in_access", 32'(apb_bus.PENABLE), 32'h1);
    #1 PRESET = 1'b1;
    #1;
    check("mid_reset.psel",    32'(apb_bus.PSEL), 32'h0);
    check("mid_reset.penable", 32'(apb_bus.PENABLE), 32'h0);
    check("mid_reset.ready",   32'(ready), 32'h0);
    check("mid_reset.paddr",   apb_bus.PADDR, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
    check_txn("post_reset_wr", 1'b1, 32'h1000_0000, 32'h0000_0042, 32'h0, 1, 1'b0, 40,
              3, 1'b0, 32'h0, 4'b0001);

    // Randomized transfers against the model
    for (int n = 0; n < 40; n++) begin
      bit          wr, hold;
      logic [31:0] a, wd, rd;
      int          stall, lat;
      logic        e;
      logic [31:0] r;
      logic [3:0]  ps;
      wr    = 1'($urandom_range(0, 1));
      hold  = ($urandom_range(0, 3) == 0);
      stall = $urandom_range(0, 5);
      wd    = $urandom;
      rd    = $urandom;
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = BASE + 32'h4000 + ($urandom_range(0, 255) & ~32'd3);
        default: a = BASE + ($urandom_range(0, 16383) & ~32'd3);
      endcase
      model_expect(wr, a, rd, stall, lat, e, r, ps);
      check_txn($sformatf("rand%0d", n), wr, a, wd, rd, stall, hold, 40, lat, e, r, ps);
    end
    idle_checks("final", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
